// File: rtl/sram_frame_looper_if.sv
// Video-side and SRAM-control signals of the frame looper.
// The looper takes the master view; the video source/SRAM side takes the slave view.
interface sram_frame_looper_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              rec;
    logic              play_en;
    logic              display_en;
    logic              frame_start;
    logic [11:0]       h_count;
    logic [11:0]       v_count;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              cs_n;
    logic              we_n;
    logic              oe_n;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [1:0]        mode;
    logic              full;
    logic              miss;

    modport master (
        input  rec, play_en, display_en, frame_start, h_count, v_count, din,
        output addr, cs_n, we_n, oe_n, dout, dout_valid, mode, full, miss
    );

    modport slave (
        output rec, play_en, display_en, frame_start, h_count, v_count, din,
        input  addr, cs_n, we_n, oe_n, dout, dout_valid, mode, full, miss
    );
endinterface

// File: rtl/sram_frame_looper.sv
// Records decimated video pixels into an asynchronous SRAM and plays them back,
// one frame at a time; mode and address restart only at frame boundaries.
module sram_frame_looper #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 8,
    parameter int H_DECIM     = 1,
    parameter int V_DECIM     = 1,
    parameter int FRAME_WORDS = 2**ADDR_W - 1
) (
    input  logic               clk_in,
    input  logic               reset,
    inout  wire [DATA_W-1:0]   io,
    sram_frame_looper_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_LATCH
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_t;

    localparam logic [11:0]       H_MASK    = 12'((1 << H_DECIM) - 1);
    localparam logic [11:0]       V_MASK    = 12'((1 << V_DECIM) - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    state_t            r_state;
    mode_t             r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic              r_full;
    logic              r_miss;
    logic              r_fs_pending;
    logic [DATA_W-1:0] r_wdata;
    logic              r_io_oe;
    logic              r_we_n;
    logic              r_oe_n;
    logic              r_cs_n;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;

    logic  w_decim_ok;
    logic  w_fs_apply;
    mode_t w_fs_mode;
    mode_t w_eff_mode;
    logic  w_eff_full;
    logic  w_slot;
    logic  w_last;

    // A frame update applied this cycle is seen by a coincident slot.
    always_comb begin
        w_decim_ok = ((bus.h_count & H_MASK) == '0) && ((bus.v_count & V_MASK) == '0);
        w_fs_apply = (r_state == S_IDLE) && (bus.frame_start || r_fs_pending);
        w_fs_mode  = MODE_IDLE;
        if (!bus.rec)
            w_fs_mode = MODE_REC;
        else if (bus.play_en)
            w_fs_mode = MODE_PLAY;
        w_eff_mode = w_fs_apply ? w_fs_mode : r_mode;
        w_eff_full = w_fs_apply ? 1'b0 : r_full;
        w_slot     = bus.display_en && (w_eff_mode != MODE_IDLE) && w_decim_ok && !w_eff_full;
        w_last     = (r_addr == LAST_ADDR);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= MODE_IDLE;
            r_addr       <= '0;
            r_full       <= 1'b0;
            r_miss       <= 1'b0;
            r_fs_pending <= 1'b0;
            r_wdata      <= '0;
            r_io_oe      <= 1'b0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;

            if (bus.frame_start && (r_state != S_IDLE))
                r_fs_pending <= 1'b1;

            if (w_fs_apply) begin
                r_fs_pending <= 1'b0;
                r_mode       <= w_fs_mode;
                r_cs_n       <= (w_fs_mode == MODE_IDLE);
                r_addr       <= '0;
                r_full       <= 1'b0;
                r_miss       <= 1'b0;
            end

            if (w_slot && (r_state != S_IDLE))
                r_miss <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_slot) begin
                        if (w_eff_mode == MODE_REC) begin
                            r_state <= W_SETUP;
                            r_wdata <= bus.din;
                            r_io_oe <= 1'b1;
                            r_we_n  <= 1'b1;
                        end else begin
                            r_state <= R_SETUP;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                W_SETUP: begin
                    r_state <= W_STROBE;
                    r_we_n  <= 1'b0;
                end
                W_STROBE: begin
                    r_state <= W_HOLD;
                    r_we_n  <= 1'b1;
                end
                W_HOLD: begin
                    r_state <= S_IDLE;
                    r_io_oe <= 1'b0;
                    if (w_last)
                        r_full <= 1'b1;
                    else
                        r_addr <= r_addr + ADDR_W'(1);
                end
                R_SETUP: begin
                    r_state      <= R_LATCH;
                    r_dout       <= io;
                    r_dout_valid <= 1'b1;
                end
                R_LATCH: begin
                    r_state <= S_IDLE;
                    r_oe_n  <= 1'b1;
                    if (w_last)
                        r_full <= 1'b1;
                    else
                        r_addr <= r_addr + ADDR_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io             = r_io_oe ? r_wdata : 'z;
    assign bus.addr       = r_addr;
    assign bus.cs_n       = r_cs_n;
    assign bus.we_n       = r_we_n;
    assign bus.oe_n       = r_oe_n;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.mode       = r_mode;
    assign bus.full       = r_full;
    assign bus.miss       = r_miss;
endmodule

// File: tb/tb_sram_frame_looper.sv
// Directed bench for sram_frame_looper: one instance with default geometry and
// one undecimated instance with a 4-word frame, each backed by a small SRAM model.
module tb_sram_frame_looper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_frame_looper_if #(.ADDR_W(18), .DATA_W(8)) bus_a ();
    sram_frame_looper_if #(.ADDR_W(4),  .DATA_W(8)) bus_b ();
    wire [7:0] io_a;
    wire [7:0] io_b;

    sram_frame_looper #(.ADDR_W(18), .DATA_W(8), .H_DECIM(1), .V_DECIM(1)) dut_a (
        .clk_in(clk), .reset(rst), .io(io_a), .bus(bus_a)
    );

    sram_frame_looper #(.ADDR_W(4), .DATA_W(8), .H_DECIM(0), .V_DECIM(0), .FRAME_WORDS(4)) dut_b (
        .clk_in(clk), .reset(rst), .io(io_b), .bus(bus_b)
    );

    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:15];
    int unsigned wr_a = 0;
    int unsigned wr_b = 0;

    assign io_a = (!bus_a.cs_n && !bus_a.oe_n) ? mem_a[bus_a.addr[7:0]] : 'z;
    assign io_b = (!bus_b.cs_n && !bus_b.oe_n) ? mem_b[bus_b.addr] : 'z;

    always @(posedge clk) begin
        if (rst) begin
            wr_a <= 0;
            wr_b <= 0;
        end else begin
            if (!bus_a.cs_n && !bus_a.we_n) begin
                mem_a[bus_a.addr[7:0]] <= io_a;
                wr_a <= wr_a + 1;
            end
            if (!bus_b.cs_n && !bus_b.we_n) begin
                mem_b[bus_b.addr] <= io_b;
                wr_b <= wr_b + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vals_a [16] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E, 8'hC3,
                                8'h3C, 8'h11, 8'h22, 8'h44, 8'h88, 8'h96, 8'h69, 8'hE7};
    logic [7:0] vals_b [6]  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        bus_a.rec = 1'b1; bus_a.play_en = 1'b0; bus_a.display_en = 1'b0; bus_a.frame_start = 1'b0;
        bus_a.h_count = '0; bus_a.v_count = '0; bus_a.din = '0;
        bus_b.rec = 1'b1; bus_b.play_en = 1'b0; bus_b.display_en = 1'b0; bus_b.frame_start = 1'b0;
        bus_b.h_count = '0; bus_b.v_count = '0; bus_b.din = '0;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_mode",  bus_a.mode, 0);
        check("rst_addr",  bus_a.addr, 0);
        check("rst_we_n",  bus_a.we_n, 1);
        check("rst_oe_n",  bus_a.oe_n, 1);
        check("rst_cs_n",  bus_a.cs_n, 1);
        check("rst_full",  bus_a.full, 0);
        check("rst_miss",  bus_a.miss, 0);
        check("rst_dv",    bus_a.dout_valid, 0);
        check("rst_dout",  bus_a.dout, 0);
        rst = 1'b0;
        tick();

        // Record 16 pixels
        bus_a.rec = 1'b0; bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        check("rec_mode", bus_a.mode, 1);
        check("rec_cs_n", bus_a.cs_n, 0);
        check("rec_addr0", bus_a.addr, 0);
        for (int i = 0; i < 16; i++) begin
            bus_a.din = vals_a[i]; bus_a.display_en = 1'b1;
            tick();
            bus_a.display_en = 1'b0;
            check("wsetup_io", io_a, vals_a[i]);
            check("wsetup_we_n", bus_a.we_n, 1);
            tick();
            check("wstrobe_we_n", bus_a.we_n, 0);
            check("wstrobe_io", io_a, vals_a[i]);
            tick();
            check("whold_we_n", bus_a.we_n, 1);
            check("whold_io", io_a, vals_a[i]);
            tick();
            check("w_addr_adv", bus_a.addr, i + 1);
        end
        check("rec_writes", wr_a, 16);
        check("rec_full", bus_a.full, 0);
        check("rec_miss", bus_a.miss, 0);

        // Playback: frame_start and slot together, slot taken as a read at addr 0
        bus_a.rec = 1'b1; bus_a.play_en = 1'b1; bus_a.frame_start = 1'b1; bus_a.display_en = 1'b1;
        tick();
        bus_a.frame_start = 1'b0; bus_a.display_en = 1'b0;
        check("play_mode", bus_a.mode, 2);
        check("play_addr0", bus_a.addr, 0);
        check("rsetup_oe_n", bus_a.oe_n, 0);
        check("rsetup_we_n", bus_a.we_n, 1);
        check("rsetup_dv", bus_a.dout_valid, 0);
        tick();
        check("rlatch_dv", bus_a.dout_valid, 1);
        check("rlatch_dout", bus_a.dout, vals_a[0]);
        tick();
        check("ridle_dv", bus_a.dout_valid, 0);
        check("ridle_oe_n", bus_a.oe_n, 1);
        check("ridle_addr", bus_a.addr, 1);
        for (int i = 1; i < 16; i++) begin
            if (i == 8) begin
                bus_a.rec = 1'b0; bus_a.play_en = 1'b0;
            end
            bus_a.display_en = 1'b1;
            tick();
            bus_a.display_en = 1'b0;
            check("rsetup_oe_n", bus_a.oe_n, 0);
            tick();
            check("rlatch_dv", bus_a.dout_valid, 1);
            check("rlatch_dout", bus_a.dout, vals_a[i]);
            check("rlatch_addr", bus_a.addr, i);
            tick();
            check("ridle_dv", bus_a.dout_valid, 0);
            check("play_mode_held", bus_a.mode, 2);
        end
        check("play_no_writes", wr_a, 16);

        // frame_start during W_STROBE is deferred until the write finishes
        bus_a.rec = 1'b0; bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        check("fs_rec_mode", bus_a.mode, 1);
        check("fs_rec_addr", bus_a.addr, 0);
        bus_a.din = 8'h5F; bus_a.display_en = 1'b1;
        tick();
        bus_a.display_en = 1'b0;
        tick();
        check("fsw_strobe_we_n", bus_a.we_n, 0);
        bus_a.rec = 1'b1; bus_a.play_en = 1'b1; bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        check("fsw_hold_we_n", bus_a.we_n, 1);
        check("fsw_hold_io", io_a, 8'h5F);
        check("fsw_hold_mode", bus_a.mode, 1);
        tick();
        tick();
        check("fsw_addr", bus_a.addr, 0);
        check("fsw_mode", bus_a.mode, 2);
        check("fsw_written", mem_a[0], 8'h5F);
        check("fsw_writes", wr_a, 17);

        // Reset during W_STROBE
        bus_a.rec = 1'b0; bus_a.play_en = 1'b0; bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        check("rw_mode", bus_a.mode, 1);
        bus_a.din = 8'hC7; bus_a.display_en = 1'b1;
        tick();
        bus_a.display_en = 1'b0;
        tick();
        check("rw_strobe_we_n", bus_a.we_n, 0);
        rst = 1'b1;
        tick();
        check("rw_we_n", bus_a.we_n, 1);
        check("rw_oe_n", bus_a.oe_n, 1);
        check("rw_mode0", bus_a.mode, 0);
        check("rw_addr0", bus_a.addr, 0);
        check("rw_cs_n", bus_a.cs_n, 1);
        check("rw_dout", bus_a.dout, 0);
        tick();
        check("rw_no_strobe", bus_a.we_n, 1);
        rst = 1'b0;
        bus_a.rec = 1'b1;
        tick();

        // 4-word frame: six slots, only four writes land
        bus_b.rec = 1'b0; bus_b.frame_start = 1'b1;
        tick();
        bus_b.frame_start = 1'b0;
        check("b_rec_mode", bus_b.mode, 1);
        for (int i = 0; i < 6; i++) begin
            bus_b.din = vals_b[i]; bus_b.display_en = 1'b1;
            tick();
            bus_b.display_en = 1'b0;
            repeat (3) tick();
        end
        check("b_full_addr", bus_b.addr, 3);
        check("b_full", bus_b.full, 1);
        check("b_writes", wr_b, 4);
        check("b_full_miss", bus_b.miss, 0);
        check("b_mem3", mem_b[3], 8'h43);

        bus_b.rec = 1'b1; bus_b.play_en = 1'b1; bus_b.frame_start = 1'b1;
        tick();
        bus_b.frame_start = 1'b0;
        check("b_full_clr", bus_b.full, 0);
        check("b_addr_clr", bus_b.addr, 0);
        check("b_play_mode", bus_b.mode, 2);

        // Undecimated playback with slots on every pixel
        pulses = 0;
        bus_b.h_count = 12'd0; bus_b.display_en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            bus_b.h_count = 12'(c);
            tick();
            if (bus_b.dout_valid) pulses++;
            if (c == 1) check("b_miss_first", bus_b.miss, 0);
            if (c == 2) begin
                check("b_miss_second", bus_b.miss, 1);
                check("b_dout0", bus_b.dout, 8'h10);
            end
            if (c == 5) check("b_dout1", bus_b.dout, 8'h21);
        end
        bus_b.display_en = 1'b0;
        check("b_pulses", pulses, 3);
        check("b_read_addr", bus_b.addr, 3);
        check("b_miss_sticky", bus_b.miss, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_frame_looper.md
SRAM_FRAME_LOOPER -- requirements
Module: sram_frame_looper

Interface
REQ-001 Parameter ADDR_W, default 18: SRAM address width.
REQ-002 Parameter DATA_W, default 8: SRAM data width.
REQ-003 Parameter H_DECIM, default 1: log2 horizontal decimation; a sample slot needs h_count[H_DECIM-1:0]==0.
REQ-004 Parameter V_DECIM, default 1: log2 vertical decimation; a sample slot needs v_count[V_DECIM-1:0]==0.
REQ-005 Parameter FRAME_WORDS, default 2**ADDR_W-1: number of SRAM words per frame.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk_in  in  1  sole clock, every register on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 rec  in  1  record request, active low, sampled only at frame boundaries.
REQ-010 play_en  in  1  playback request, active high, sampled only at frame boundaries; rec low takes priority.
REQ-011 display_en  in  1  high when the pixel is in the visible region.
REQ-012 frame_start  in  1  one-cycle pulse at the first pixel of a frame.
REQ-013 h_count, v_count  in  12 each  current pixel coordinates.
REQ-014 din  in  DATA_W  pixel data to record.
REQ-015 addr  out  ADDR_W  SRAM address.
REQ-016 io  inout  DATA_W  SRAM data bus.
REQ-017 cs_n, we_n, oe_n  out  1 each  SRAM strobes, active low.
REQ-018 dout  out  DATA_W  data read back during playback.
REQ-019 dout_valid  out  1  one-cycle pulse when dout updates.
REQ-020 mode  out  2  current mode: 0 IDLE, 1 REC, 2 PLAY.
REQ-021 full  out  1  sticky; the frame has run out of address space.
REQ-022 miss  out  1  sticky; a sample slot arrived while an access was in progress.

Function
REQ-023 Slot: a slot occurs in a cycle with display_en=1, mode!=IDLE, both decimation conditions true, and full=0.
REQ-024 FSM states: S_IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_LATCH.
REQ-025 S_IDLE: on a slot, go to W_SETUP if mode is REC, or to R_SETUP if mode is PLAY.
REQ-026 W_SETUP: latch din into the write register, drive io, we_n=1.
REQ-027 W_STROBE: we_n=0, io still driven.
REQ-028 W_HOLD: we_n=1, io still driven; then return to S_IDLE and advance the address.
REQ-029 R_SETUP: oe_n=0, io high-impedance.
REQ-030 R_LATCH: oe_n=0; dout<=io, dout_valid=1 for this cycle only; then return to S_IDLE and advance the address.
REQ-031 io SHALL be driven only in W_SETUP, W_STROBE and W_HOLD; it is high-impedance in every other state.
REQ-032 oe_n SHALL be 0 only in R_SETUP and R_LATCH.
REQ-033 we_n and oe_n SHALL never both be low.
REQ-034 cs_n SHALL be 0 whenever mode!=IDLE, and 1 otherwise.
REQ-035 Address advance: addr+1, but if addr==FRAME_WORDS-1, addr holds and full<=1.
REQ-036 A slot that occurs while the FSM is not in S_IDLE is dropped and sets miss<=1.
REQ-037 frame_start with FSM in S_IDLE SHALL, at the next edge: set addr<=0, clear full and miss, and set mode from rec/play_en.
REQ-038 frame_start arriving mid-access SHALL be held pending, then applied on the cycle the FSM returns to S_IDLE; the in-flight access completes unchanged.
REQ-039 A frame_start and a slot in the same S_IDLE cycle: the frame update is applied first, and the slot is taken under the new mode at addr 0.
REQ-040 Changes on rec or play_en between frame_start pulses SHALL have no effect.

Reset
REQ-041 Reset SHALL force: FSM=S_IDLE, mode=0, addr=0, dout=0, dout_valid=0, full=0, miss=0, we_n=1, oe_n=1, cs_n=1, io high-impedance, pending frame_start cleared.
REQ-042 Reset asserted mid-write SHALL raise we_n to 1 and release io at the next edge, with no further strobe.

Verification
REQ-043 rec=0, frame_start, first slot with din=0xA5 -> cycles: W_SETUP (io=0xA5, we_n=1), W_STROBE (we_n=0), W_HOLD (we_n=1), then addr=1.
REQ-044 Record 16 slots, then play_en=1, rec=1, frame_start -> dout_valid pulses reproduce the recorded sequence at addr 0..15, each dout one cycle after oe_n fell.
REQ-045 H_DECIM=0, V_DECIM=0, PLAY mode -> slots every cycle; miss=1 after the second slot; only every 3rd pixel read.
REQ-046 FRAME_WORDS=4, record 6 slots -> addr stops at 3, full=1, 4 writes only; next frame_start clears full.
REQ-047 frame_start during W_STROBE -> W_HOLD completes, then addr=0 and mode updated.
REQ-048 reset during W_STROBE -> next edge we_n=1, io high-impedance, mode=0, addr=0.
